sensor_monitor_ctrl: RTL and testbench

//   Periodic sampling and alarm controller for the 4-bit sensor fault logic.

---
 rtl/sensor_monitor_ctrl.sv | 102 ++++++++++
 tb/tb_sensor_monitor_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sensor_monitor_ctrl.sv
// sensor_monitor_ctrl: periodic sensor sampling with debounced, ack-held fault alarm
module sensor_monitor_ctrl #(
    parameter int SAMPLE_PERIOD = 8,
    parameter int DEBOUNCE_CNT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] sensors,
    input  logic       ack,
    output logic       sample_strobe,
    output logic       alarm,
    output logic [3:0] fault_code,
    output logic       active
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    typedef enum logic [2:0] {IDLE, MONITOR, CONFIRM, ALARM, CLEAR_WAIT} state_t;
    state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [3:0] pending_q, pending_d, fault_code_q, fault_code_d;
    logic alarm_q, alarm_d;
    logic strobe, err;
    assign strobe = (state_q != IDLE) && (timer_q == TW'(SAMPLE_PERIOD - 1));
    assign err = sensors[0] | (sensors[1] & (sensors[2] | sensors[3]));
    always_comb begin
        state_d      = state_q;
        timer_d      = (state_q == IDLE || strobe) ? '0 : timer_q + 1'b1;
        deb_d        = deb_q;
        pending_d    = pending_q;
        fault_code_d = fault_code_q;
        alarm_d      = alarm_q;
        if (!enable) begin
            state_d = IDLE;
            timer_d = '0;
            deb_d   = '0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = MONITOR;
                    deb_d   = '0;
                end
                MONITOR: if (strobe && err) begin
                    pending_d = sensors;
                    deb_d     = DW'(1);
                    if (DEBOUNCE_CNT == 1) begin
                        state_d      = ALARM;
                        alarm_d      = 1'b1;
                        fault_code_d = sensors;
                    end else begin
                        state_d = CONFIRM;
                    end
                end
                CONFIRM: if (strobe) begin
                    if (!err) begin
                        deb_d   = '0;
                        state_d = MONITOR;
                    end else begin
                        deb_d = deb_q + 1'b1;
                        if (int'(deb_q) + 1 == DEBOUNCE_CNT) begin
                            state_d      = ALARM;
                            alarm_d      = 1'b1;
                            fault_code_d = pending_q;
                        end
                    end
                end
                ALARM: if (ack) begin
                    state_d = CLEAR_WAIT;
                    alarm_d = 1'b0;
                end
                CLEAR_WAIT: if (strobe && !err) begin
                    state_d = MONITOR;
                    deb_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            deb_q        <= '0;
            pending_q    <= '0;
            fault_code_q <= '0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            deb_q        <= deb_d;
            pending_q    <= pending_d;
            fault_code_q <= fault_code_d;
            alarm_q      <= alarm_d;
        end
    end
    assign sample_strobe = strobe;
    assign alarm         = alarm_q;
    assign fault_code    = fault_code_q;
    assign active        = state_q != IDLE;
endmodule

// File: tb/tb_sensor_monitor_ctrl.sv
// tb_sensor_monitor_ctrl: directed vector table plus hand sequences for sensor_monitor_ctrl
module tb_sensor_monitor_ctrl;
    logic clk = 1'b0;
    logic rst, enable, ack;
    logic [3:0] sensors;
    logic sample_strobe, alarm, active;
    logic [3:0] fault_code;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic       en;
        logic [3:0] sens;
        logic       ack;
        int         n;
        logic       exp_alarm;
        logic [3:0] exp_code;
        logic       exp_active;
    } vec_t;
    vec_t vecs[16];
    sensor_monitor_ctrl #(.SAMPLE_PERIOD(8), .DEBOUNCE_CNT(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sensors(sensors), .ack(ack),
        .sample_strobe(sample_strobe), .alarm(alarm), .fault_code(fault_code), .active(active)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic run_strobes(input int n);
        int seen = 0;
        for (int i = 0; i < 8 * n + 16 && seen < n; i++) begin
            if (sample_strobe) seen++;
            tick();
        end
        check("strobe_budget", seen, n);
    endtask
    initial begin
        vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1,  1'b0, 4'b1010, 1'b1};
        vecs[1]  = '{1'b1, 4'b0001, 1'b0, 2,  1'b0, 4'b1010, 1'b1};
        vecs[2]  = '{1'b1, 4'b0000, 1'b0, 1,  1'b0, 4'b1010, 1'b1};
        vecs[3]  = '{1'b1, 4'b0001, 1'b0, 2,  1'b0, 4'b1010, 1'b1};
        vecs[4]  = '{1'b1, 4'b0000, 1'b0, 1,  1'b0, 4'b1010, 1'b1};
        vecs[5]  = '{1'b1, 4'b1100, 1'b0, 10, 1'b0, 4'b1010, 1'b1};
        vecs[6]  = '{1'b1, 4'b0011, 1'b0, 1,  1'b0, 4'b1010, 1'b1};
        vecs[7]  = '{1'b1, 4'b0101, 1'b0, 2,  1'b1, 4'b0011, 1'b1};
        vecs[8]  = '{1'b1, 4'b0000, 1'b1, 0,  1'b0, 4'b0011, 1'b1};
        vecs[9]  = '{1'b1, 4'b0111, 1'b0, 3,  1'b0, 4'b0011, 1'b1};
        vecs[10] = '{1'b1, 4'b0000, 1'b0, 1,  1'b0, 4'b0011, 1'b1};
        vecs[11] = '{1'b0, 4'b0000, 1'b0, 0,  1'b0, 4'b0011, 1'b0};
        vecs[12] = '{1'b1, 4'b0000, 1'b0, 0,  1'b0, 4'b0011, 1'b1};
        vecs[13] = '{1'b1, 4'b1011, 1'b1, 3,  1'b1, 4'b1011, 1'b1};
        vecs[14] = '{1'b1, 4'b0000, 1'b1, 0,  1'b0, 4'b1011, 1'b1};
        vecs[15] = '{1'b1, 4'b0000, 1'b0, 1,  1'b0, 4'b1011, 1'b1};
        rst = 1'b1; enable = 1'b1; ack = 1'b1; sensors = 4'b1111;
        tick();
        tick();
        check("rst_alarm", alarm, 0);
        check("rst_code", fault_code, 0);
        check("rst_active", active, 0);
        check("rst_strobe", sample_strobe, 0);
        rst = 1'b0; enable = 1'b0; ack = 1'b0; sensors = 4'b0000;
        tick();
        enable = 1'b1; sensors = 4'b0110;
        tick();
        check("enable_active", active, 1);
        for (int k = 1; k <= 26; k++) begin
            check($sformatf("strobe_c%0d", k), sample_strobe, (k % 8) == 0);
            check($sformatf("alarm_c%0d", k), alarm, k >= 25);
            tick();
        end
        check("code_0110", fault_code, 4'b0110);
        ack = 1'b1; sensors = 4'b1010;
        tick();
        ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("clear_wait_alarm", alarm, 0);
            tick();
        end
        sensors = 4'b0000;
        run_strobes(1);
        sensors = 4'b1010;
        run_strobes(2);
        check("rearm_alarm_early", alarm, 0);
        run_strobes(1);
        check("rearm_alarm", alarm, 1);
        check("rearm_code", fault_code, 4'b1010);
        for (int k = 0; k < 8 && !sample_strobe; k++) tick();
        check("collide_strobe", sample_strobe, 1);
        ack = 1'b1; sensors = 4'b0000;
        tick();
        ack = 1'b0;
        check("collide_alarm", alarm, 0);
        check("collide_active", active, 1);
        for (int i = 0; i < 16; i++) begin
            enable = vecs[i].en; sensors = vecs[i].sens; ack = vecs[i].ack;
            if (vecs[i].n == 0) tick();
            else run_strobes(vecs[i].n);
            check($sformatf("vec%0d_alarm", i), alarm, vecs[i].exp_alarm);
            check($sformatf("vec%0d_code", i), fault_code, vecs[i].exp_code);
            check($sformatf("vec%0d_active", i), active, vecs[i].exp_active);
        end
        ack = 1'b0; sensors = 4'b0001;
        run_strobes(3);
        check("dis_pre_alarm", alarm, 1);
        check("dis_pre_code", fault_code, 4'b0001);
        enable = 1'b0;
        tick();
        check("dis_alarm", alarm, 0);
        check("dis_active", active, 0);
        check("dis_code", fault_code, 4'b0001);
        for (int k = 0; k < 10; k++) begin
            check("idle_strobe", sample_strobe, 0);
            tick();
        end
        enable = 1'b1;
        tick();
        run_strobes(2);
        check("confirm_alarm", alarm, 0);
        check("confirm_active", active, 1);
        rst = 1'b1;
        tick();
        check("midrst_alarm", alarm, 0);
        check("midrst_code", fault_code, 0);
        check("midrst_active", active, 0);
        check("midrst_strobe", sample_strobe, 0);
        rst = 1'b0; enable = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
